irq_latch_enc: RTL and testbench
================================

# irq_latch_enc

Interrupt request front-end that captures eight single-bit request lines and applies a per-line mask. It priority-encodes the highest pending line into a 3-bit vector and presents it to a consumer over a valid/ack handshake. It tracks the serviced request until end-of-interrupt. It sits directly upstream of the vector consumer and wraps the team's 8:3 priority-encode function with the state (pending, mask, in-service) that function lacks.

## Interface
- `N`, 8: number of request lines (fixed at 8 in this revision).
- `IDW`, 3: vector width, log2(N).
- `EDGE`, 1: 1 = rising-edge capture of `req`; 0 = level capture (pending follows `req` while high).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines, synchronous to `clk`.
- `mask_wr`  in  1  write strobe for mask register.
- `mask_in`  in  8  new mask value; bit=1 masks that line.
- `irq_ack`  in  1  consumer accepts presented vector.
- `eoi`  in  1  consumer signals end of service.
- `irq_valid`  out  1  vector presented.
- `irq_id`  out  3  presented vector, bit 7 → 3'b111 … bit 0 → 3'b000.
- `busy`  out  1  high while in SERVICE.
- `pend_q`  out  8  pending register.
- `mask_q`  out  8  mask register.

## Operation
- Reset values:
  - `pend_q`=8'h00, `mask_q`=8'hFF (all masked), `req_d`=8'h00.
  - `irq_valid`=0, `irq_id`=3'b000, `busy`=0, state=IDLE.
- Capture:
  - EDGE=1: `pend[k]` sets when `req[k]`=1 and `req_d[k]`=0.
  - Because `req_d` resets to 0, a line held high through reset registers one request.
  - EDGE=0: `pend[k]` sets whenever `req[k]`=1.
- Eligible = `pend_q & ~mask_q`. The highest set bit wins; bit 7 is highest priority.
- Masking never clears pending. A masked pending bit becomes eligible once unmasked.
- States:
  - IDLE: if eligible≠0 → PRESENT. Load `irq_id` with the encoded eligible value and set `irq_valid`=1.
  - PRESENT: hold `irq_id` and `irq_valid` stable. On `irq_ack`=1 → SERVICE: clear `pend[irq_id]`, `irq_valid`=0, `busy`=1.
  - SERVICE: on `eoi`=1 → IDLE with `busy`=0.
- No preemption. A higher-priority request arriving in PRESENT or SERVICE only sets pending.
- Simultaneous set and clear of the same pending bit: set wins, so the bit stays 1.
- A mask write in PRESENT does not retract or change the presented vector.
- A mask write takes effect on `mask_q` at the next edge.
- `irq_ack` outside PRESENT and `eoi` outside SERVICE are ignored.
- `rst` asserted in any state returns all state to reset values at that edge, regardless of other inputs.

## Timing
- `req` rises before edge T:
  - `pend_q` bit set after T.
  - `irq_valid`=1 with `irq_id` after T+1.
  - Total request-to-valid latency is 2 cycles if the line is unmasked and the block is idle.
- `irq_ack` sampled high at edge A while in PRESENT: `irq_valid`=0, `busy`=1 and the pend bit clears after A.
- `eoi` sampled at edge E: `busy`=0 after E. The next vector can be valid after E+1 at the earliest.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `irq_pkg`:
  - constants `N`=8 and `IDW`=3;
  - state enum IDLE/PRESENT/SERVICE (2-bit encoding).
- Sub-module `prio_enc8`:
  - combinational 8:3 priority encoder, bit 7 highest;
  - outputs `id[2:0]` and `any`;
  - instantiated once on the eligible vector.
- Top-level contents: edge detect, pending/mask registers, FSM, output registers.

## Test plan
- Reset with `req`=0 → all outputs at reset values; a `req`=8'h01 pulse with default mask produces no `irq_valid`.
- Write mask 8'h00, pulse `req`=8'h24 → after 2 cycles `irq_valid`=1, `irq_id`=3'b101. Ack → `pend_q`=8'h04. EOI, then next valid shows `irq_id`=3'b010.
- In PRESENT with `irq_id`=3'b010, pulse `req[7]` → `irq_id` stays 3'b010 until ack. After EOI, 3'b111 is presented.
- Mask 8'h80 with pending 8'h81 → `irq_id`=3'b000. Then unmask bit 7 while in SERVICE → after EOI `irq_id`=3'b111.
- Re-pulse `req[3]` in the same cycle as the ack for `irq_id`=3'b011 → `pend_q[3]` remains 1 and id 3'b011 is re-presented after EOI.
- Assert `rst` during SERVICE with `pend_q`=8'hF0 → next cycle `busy`=0, `pend_q`=8'h00, `mask_q`=8'hFF, `irq_valid`=0.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and FSM state type for the interrupt front-end
package irq_pkg;
    localparam int N   = 8;
    localparam int IDW = 3;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8:3 priority encoder, bit 7 highest
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N-1:0]   v,
    output logic [IDW-1:0] id,
    output logic           any
);
    // ascending scan so the highest set bit is the last one written
    always_comb begin
        id  = '0;
        any = |v;
        for (int i = 0; i < N; i++)
            if (v[i]) id = i[IDW-1:0];
    end
endmodule

// File: rtl/irq_latch_enc.sv
// irq_latch_enc: latches masked interrupt requests and hands out prioritised vectors over valid/ack/eoi
module irq_latch_enc
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           mask_wr,
    input  logic [N-1:0]   mask_in,
    input  logic           irq_ack,
    input  logic           eoi,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    output logic           busy,
    output logic [N-1:0]   pend_q,
    output logic [N-1:0]   mask_q
);
    state_t         state;
    logic [N-1:0]   req_d;
    logic [N-1:0]   set;
    logic [N-1:0]   clr;
    logic [IDW-1:0] enc_id;
    logic           enc_any;

    prio_enc8 u_enc (
        .v   (pend_q & ~mask_q),
        .id  (enc_id),
        .any (enc_any)
    );

    // new requests to latch, and the bit retired by an accepted vector
    always_comb begin
        set = EDGE ? (req & ~req_d) : req;
        clr = (state == PRESENT && irq_ack) ? ({{(N-1){1'b0}}, 1'b1} << irq_id) : '0;
    end

    // capture, mask and handshake state; set beats clear on the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_d     <= '0;
            pend_q    <= '0;
            mask_q    <= '1;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            busy      <= 1'b0;
        end else begin
            req_d  <= req;
            pend_q <= (pend_q & ~clr) | set;
            if (mask_wr) mask_q <= mask_in;
            case (state)
                IDLE: if (enc_any) begin
                    state     <= PRESENT;
                    irq_id    <= enc_id;
                    irq_valid <= 1'b1;
                end
                PRESENT: if (irq_ack) begin
                    state     <= SERVICE;
                    irq_valid <= 1'b0;
                    busy      <= 1'b1;
                end
                SERVICE: if (eoi) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    irq_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_latch_enc.sv
// tb_irq_latch_enc: directed vector table plus reset corner sequences
module tb_irq_latch_enc;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_in = '0;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pend_q;
    logic [7:0] mask_q;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] req;
        logic       mw;
        logic [7:0] mi;
        logic       ack;
        logic       eoi;
        logic       v;
        logic [2:0] id;
        logic       b;
        logic [7:0] p;
        logic [7:0] m;
    } vec_t;

    vec_t vecs[$];

    irq_latch_enc #(.EDGE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .irq_ack   (irq_ack),
        .eoi       (eoi),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .busy      (busy),
        .pend_q    (pend_q),
        .mask_q    (mask_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic mw, input logic [7:0] mi, input logic a, input logic e,
                       input logic v, input logic [2:0] id, input logic b, input logic [7:0] p, input logic [7:0] m);
        vec_t t;
        t.req = r; t.mw = mw; t.mi = mi; t.ack = a; t.eoi = e;
        t.v = v; t.id = id; t.b = b; t.p = p; t.m = m;
        vecs.push_back(t);
    endtask

    task automatic check_all(input int idx, input logic v, input logic [2:0] id, input logic b,
                             input logic [7:0] p, input logic [7:0] m);
        chk("irq_valid", idx, {7'b0, irq_valid}, {7'b0, v});
        chk("irq_id", idx, {5'b0, irq_id}, {5'b0, id});
        chk("busy", idx, {7'b0, busy}, {7'b0, b});
        chk("pend_q", idx, pend_q, p);
        chk("mask_q", idx, mask_q, m);
    endtask

    initial begin
        //   req  mw mi    ack eoi | v id     b  pend   mask
        add(8'h01, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h01, 8'hFF);
        add(8'h00, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h01, 8'hFF);
        add(8'h00, 1, 8'h00, 0, 0,  0, 3'd0, 0, 8'h01, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 0, 8'h01, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd0, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd0, 0, 8'h00, 8'h00);
        add(8'h24, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h24, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd5, 0, 8'h24, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd5, 1, 8'h04, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd5, 0, 8'h04, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd2, 0, 8'h04, 8'h00);
        add(8'h80, 0, 8'h00, 0, 0,  1, 3'd2, 0, 8'h84, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd2, 0, 8'h84, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd2, 1, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd2, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd7, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd7, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd7, 0, 8'h00, 8'h00);
        add(8'h81, 1, 8'h80, 0, 0,  0, 3'd7, 0, 8'h81, 8'h80);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd0, 0, 8'h81, 8'h80);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd0, 1, 8'h80, 8'h80);
        add(8'h00, 1, 8'h00, 0, 0,  0, 3'd0, 1, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd0, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd7, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd7, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd7, 0, 8'h00, 8'h00);
        add(8'h08, 0, 8'h00, 0, 0,  0, 3'd7, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd3, 0, 8'h08, 8'h00);
        add(8'h08, 0, 8'h00, 1, 0,  0, 3'd3, 1, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd3, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd3, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd3, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd3, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 1, 1,  0, 3'd3, 0, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 1, 1,  0, 3'd3, 0, 8'h00, 8'h00);
        add(8'h10, 0, 8'h00, 0, 0,  0, 3'd3, 0, 8'h10, 8'h00);
        add(8'h00, 1, 8'h10, 0, 0,  1, 3'd4, 0, 8'h10, 8'h10);
        add(8'h00, 0, 8'h00, 0, 0,  1, 3'd4, 0, 8'h10, 8'h10);
        add(8'h00, 0, 8'h00, 1, 0,  0, 3'd4, 1, 8'h00, 8'h10);
        add(8'h00, 1, 8'h00, 0, 1,  0, 3'd4, 0, 8'h00, 8'h00);
        add(8'h02, 0, 8'h00, 0, 0,  0, 3'd4, 0, 8'h02, 8'h00);
        add(8'h02, 0, 8'h00, 0, 0,  1, 3'd1, 0, 8'h02, 8'h00);
        add(8'h02, 0, 8'h00, 1, 0,  0, 3'd1, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,  0, 3'd1, 0, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,  0, 3'd1, 0, 8'h00, 8'h00);

        rst = 1'b1;
        step();
        step();
        check_all(-1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req; mask_wr = vecs[i].mw; mask_in = vecs[i].mi;
            irq_ack = vecs[i].ack; eoi = vecs[i].eoi;
            step();
            check_all(i, vecs[i].v, vecs[i].id, vecs[i].b, vecs[i].p, vecs[i].m);
        end

        req = 8'h01; mask_wr = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
        step();
        req = 8'hF0;
        step();
        check_all(100, 1'b1, 3'd0, 1'b0, 8'hF1, 8'h00);
        req = 8'h00; irq_ack = 1'b1;
        step();
        check_all(101, 1'b0, 3'd0, 1'b1, 8'hF0, 8'h00);
        rst = 1'b1; irq_ack = 1'b1; eoi = 1'b1; mask_wr = 1'b1; mask_in = 8'h00; req = 8'h04;
        step();
        check_all(102, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);
        rst = 1'b0; irq_ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0;
        step();
        check_all(103, 1'b0, 3'd0, 1'b0, 8'h04, 8'hFF);
        step();
        check_all(104, 1'b0, 3'd0, 1'b0, 8'h04, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
